// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the width helper for the iteration counter.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width for an N-bit operand.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_cla.sv
// N-bit carry-lookahead adder producing an (N+1)-bit sum; the MSB is the
// carry out, so accumulating A + M never loses an overflow.
module CarryLookAhead_Adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    output logic [N:0]   result
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    // Generate/propagate terms and the lookahead carry chain.
    always_comb begin
        // NOTE: every variable gets a value before any conditional or loop
        // logic, so the block stays purely combinational with no latches.
        gen   = num1 & num2;
        prop  = num1 ^ num2;
        carry = '0;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        result = {carry[N], prop ^ carry[N-1:0]};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one add-and-shift iteration per
// clock in CALC, a one-cycle done pulse in DONE, fixed N+2 cycle period.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = cnt_width(N);

    state_e           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N:0]       sum;   // {C_next, A_sum} from the adder
    logic [N:0]       acc;   // {C, A} after the conditional add

    CarryLookAhead_Adder #(.N(N)) u_cla (
        .num1   (a_q),
        .num2   (m_q),
        .result (sum)
    );

    // Next-state logic: operand load in IDLE, add-and-shift in CALC.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        acc       = {c_q, a_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // C is always 0 between iterations, so {C,A} is the no-add case.
                acc = q_q[0] ? sum : {c_q, a_q};
                {c_d, a_d, q_d} = {1'b0, acc, q_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    product_d = {a_d, q_d};
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (rst) begin
            // NOTE: the datapath registers are few, so they are reset along
            // with control; a reset leaves no stale operand or product.
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: a timing/arithmetic reference model checked every
// cycle, directed literal cases, and randomized operations.
module tb_shift_add_multiplier;
    import shift_add_multiplier_pkg::*;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation accepted at edge k shows busy for the
    // cycles after edges k..k+N-1, done after edge k+N, product a*b from
    // edge k+N on; the block is ready again at edge k+N+2.
    int             edge_n   = 0;
    int             acc_edge = -1;
    logic [2*N-1:0] pend     = '0;
    logic [2*N-1:0] exp_prod = '0;
    logic           exp_busy = 1'b0;
    logic           exp_done = 1'b0;
    logic           model_ok = 1'b0;
    state_e         exp_st;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            acc_edge = -1;
            exp_prod = '0;
            model_ok = 1'b1;
        end else begin
            if (acc_edge >= 0 && edge_n == acc_edge + N) exp_prod = pend;
            if (start && (acc_edge < 0 || edge_n >= acc_edge + N + 2)) begin
                acc_edge = edge_n;
                pend     = {{N{1'b0}}, mcand} * {{N{1'b0}}, mplier};
            end
        end
        exp_busy = (acc_edge >= 0) && (edge_n >= acc_edge) && (edge_n < acc_edge + N);
        exp_done = (acc_edge >= 0) && (edge_n == acc_edge + N);
    end

    always @(negedge clk) begin
        if (model_ok) begin
            exp_st = exp_busy ? CALC : (exp_done ? DONE : IDLE);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("product", product, exp_prod);
            check("state", dut.state_q, exp_st);
        end
    end

    // Called at the negedge after the accept edge k; lat = i when done is
    // registered at edge k+i (done then samples high at edge k+i+1).
    task automatic wait_done(input string nm, output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy && !done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok == 0) check("idle_timeout", 0, 1);
    endtask

    // Starts from a negedge with the block idle; ends at a negedge, idle.
    task automatic op(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string nm);
        int lat;
        start = 1'b1;
        mcand = a;
        mplier = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, lat);
        check({nm, "_done_edges"}, 64'(lat + 1), 64'(N + 1));
        check({nm, "_product"}, product, exp);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gap;
        int dcount;
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_product", product, 0);

        // First start accepted at the first edge after reset deasserts.
        rst = 1'b0;
        op(8'h00, 8'h00, 16'h0000, "zero");
        op(8'hFF, 8'hFF, 16'hFE01, "ff_ff");
        op(8'hFF, 8'h01, 16'h00FF, "ff_01");
        op(8'h0F, 8'hF0, 16'h0E10, "0f_f0");

        // Back-to-back with start held high; second operands are applied
        // during the first CALC and must only take effect on the re-accept.
        start = 1'b1;
        mcand = 8'h63;
        mplier = 8'h82;
        @(negedge clk);
        mcand = 8'h37;
        mplier = 8'h43;
        wait_done("b2b_first", lat);
        check("b2b_first_product", product, 16'h3246);
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                gap = i;
                break;
            end
        end
        start = 1'b0;
        check("b2b_gap", 64'(gap), 64'(N + 2));
        check("b2b_second_product", product, 16'h0E65);
        @(negedge clk);
        wait_idle();

        // Start pulsed with new operands while busy is ignored.
        start = 1'b1;
        mcand = 8'h12;
        mplier = 8'h34;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pulse_busy_seen", busy, 1);
        start = 1'b1;
        mcand = 8'hAA;
        mplier = 8'hBB;
        @(negedge clk);
        start = 1'b0;
        wait_done("pulse", lat);
        check("pulse_product", product, 16'h03A8);
        repeat (2) @(negedge clk);
        check("pulse_no_restart", busy, 0);

        // Reset at CALC cycle 4 abandons the operation.
        start = 1'b1;
        mcand = 8'h55;
        mplier = 8'h66;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("rst_no_done", 64'(dcount), 0);
        op(8'h7E, 8'h81, 16'h3F7E, "after_rst");

        // Randomized operations with varied start hold, gaps and rare resets.
        repeat (60) begin
            mcand  = 8'($urandom);
            mplier = 8'($urandom);
            start  = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
